// File: rtl/subleq_io_fifo_pkg.sv
// Shared sizing for the subleq I/O responder: data word width and default FIFO depth.
package subleq_io_fifo_pkg;

  localparam int WORD_SIZE            = 16;
  localparam int SUBLEQ_IO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/subleq_fifo.sv
// Synchronous FIFO with show-ahead head word; zero-latency dout from the read pointer.
// Callers never push when full nor pop when empty; push+pop together is legal at any level.
module subleq_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/subleq_io_fifo.sv
// I/O responder for the subleq MMIO router: RX/TX FIFOs bridging CPU req/ack to host valid/ready.
// Reads and writes each take one cycle to ack; eof halts the CPU once input has ended and RX is drained.
module subleq_io_fifo
  import subleq_io_fifo_pkg::*;
#(
  parameter int WIDTH      = WORD_SIZE,
  parameter int DEPTH_LOG2 = SUBLEQ_IO_DEPTH_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_req,
  output logic             in_ack,
  output logic [WIDTH-1:0] io_in,
  output logic             eof,
  input  logic             out_req,
  output logic             out_ack,
  input  logic [WIDTH-1:0] io_out,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  input  logic [WIDTH-1:0] host_in_data,
  input  logic             host_eof,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  output logic [WIDTH-1:0] host_out_data
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } io_state_t;

  io_state_t        rd_state_q, rd_state_d;
  io_state_t        wr_state_q, wr_state_d;
  logic [WIDTH-1:0] io_in_q, io_in_d;
  logic             eof_q, eof_d;

  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic [WIDTH-1:0]    rx_dout;
  logic [DEPTH_LOG2:0] rx_count;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic [WIDTH-1:0]    tx_dout;
  logic [DEPTH_LOG2:0] tx_count;
  logic                unused_counts;

  assign unused_counts = ^{rx_count, tx_count};

  subleq_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (host_in_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  subleq_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (io_out),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign host_in_ready = !rst && !rx_full && !eof_q;
  assign rx_push       = host_in_valid && host_in_ready;
  assign eof_d         = eof_q || host_eof;

  // The ACK state never accepts a new request, which enforces two cycles per transfer.
  always_comb begin
    rd_state_d = ST_IDLE;
    io_in_d    = io_in_q;
    rx_pop     = 1'b0;
    case (rd_state_q)
      ST_IDLE: begin
        if (in_req && !rx_empty) begin
          rd_state_d = ST_ACK;
          rx_pop     = 1'b1;
          io_in_d    = rx_dout;
        end
      end
      default: rd_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = ST_IDLE;
    tx_push    = 1'b0;
    case (wr_state_q)
      ST_IDLE: begin
        if (out_req && !tx_full) begin
          wr_state_d = ST_ACK;
          tx_push    = 1'b1;
        end
      end
      default: wr_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= ST_IDLE;
      wr_state_q <= ST_IDLE;
      io_in_q    <= '0;
      eof_q      <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      io_in_q    <= io_in_d;
      eof_q      <= eof_d;
    end
  end

  assign in_ack  = (rd_state_q == ST_ACK);
  assign io_in   = in_ack ? io_in_q : '0;
  assign out_ack = (wr_state_q == ST_ACK);
  assign eof     = eof_q && rx_empty;

  assign tx_pop         = !tx_empty && host_out_ready;
  assign host_out_valid = !tx_empty;
  assign host_out_data  = tx_dout;

endmodule

// File: tb/tb_subleq_io_fifo.sv
// Bench for subleq_io_fifo: queue-based reference model checked every cycle, plus directed scenarios.
module tb_subleq_io_fifo;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_req = 1'b0, out_req = 1'b0;
  logic         host_in_valid = 1'b0, host_eof = 1'b0, host_out_ready = 1'b0;
  logic [W-1:0] io_out = '0, host_in_data = '0;
  logic         in_ack, out_ack, eof, host_in_ready, host_out_valid;
  logic [W-1:0] io_in, host_out_data;

  subleq_io_fifo #(.WIDTH(W), .DEPTH_LOG2(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_req         (in_req),
    .in_ack         (in_ack),
    .io_in          (io_in),
    .eof            (eof),
    .out_req        (out_req),
    .out_ack        (out_ack),
    .io_out         (io_out),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_eof       (host_eof),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queues for the FIFOs, an eof flag, and "ack showing this cycle" flags.
  logic [W-1:0] m_rx[$];
  logic [W-1:0] m_tx[$];
  bit           m_eof = 1'b0, m_rd_ack = 1'b0, m_wr_ack = 1'b0;
  logic [W-1:0] m_rd_data = '0;
  bit           cmp_en = 1'b0;

  always @(posedge clk) begin
    int rxn, txn;
    bit rd_go, wr_go, rx_take, tx_take;
    if (rst) begin
      m_rx.delete();
      m_tx.delete();
      m_eof     = 1'b0;
      m_rd_ack  = 1'b0;
      m_wr_ack  = 1'b0;
      m_rd_data = '0;
    end else begin
      rxn     = m_rx.size();
      txn     = m_tx.size();
      rx_take = host_in_valid && !m_eof && (rxn < 16);
      rd_go   = in_req && !m_rd_ack && (rxn > 0);
      wr_go   = out_req && !m_wr_ack && (txn < 16);
      tx_take = host_out_ready && (txn > 0);
      if (rd_go)   m_rd_data = m_rx.pop_front();
      if (rx_take) m_rx.push_back(host_in_data);
      if (tx_take) void'(m_tx.pop_front());
      if (wr_go)   m_tx.push_back(io_out);
      m_rd_ack = rd_go;
      m_wr_ack = wr_go;
      if (host_eof) m_eof = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ack", in_ack, m_rd_ack);
      chk("m_io_in", io_in, m_rd_ack ? m_rd_data : '0);
      chk("m_out_ack", out_ack, m_wr_ack);
      chk("m_eof", eof, m_eof && (m_rx.size() == 0));
      chk("m_in_ready", host_in_ready, !rst && !m_eof && (m_rx.size() < 16));
      chk("m_out_valid", host_out_valid, m_tx.size() > 0);
      if (m_tx.size() > 0) chk("m_out_data", host_out_data, m_tx[0]);
    end
  end

  initial begin
    int acks;
    bit got;
    logic [W-1:0] seen[$];

    // Reset state
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ack", in_ack, 0);
    chk("rst_out_ack", out_ack, 0);
    chk("rst_io_in", io_in, 0);
    chk("rst_eof", eof, 0);
    chk("rst_out_valid", host_out_valid, 0);
    chk("rst_in_ready", host_in_ready, 1);
    acks = 0;
    repeat (3) begin tick(); acks += int'(in_ack) + int'(out_ack); end
    chk("rst_idle_acks", acks, 0);

    // Two reads in order, then nothing left
    host_in_valid = 1'b1; host_in_data = 16'h41; tick();
    host_in_data = 16'h42; tick();
    host_in_valid = 1'b0;
    in_req = 1'b1; tick();
    chk("rd1_ack", in_ack, 1);
    chk("rd1_data", io_in, 16'h41);
    in_req = 1'b0; tick();
    chk("rd1_pulse", in_ack, 0);
    chk("rd1_io_in_zero", io_in, 0);
    in_req = 1'b1; tick();
    chk("rd2_ack", in_ack, 1);
    chk("rd2_data", io_in, 16'h42);
    in_req = 1'b0; tick();
    in_req = 1'b1; acks = 0;
    repeat (20) begin tick(); acks += int'(in_ack); end
    chk("rd_drained_noack", acks, 0);

    // Read waiting on empty FIFO, then input arrives
    acks = 0;
    repeat (10) begin tick(); acks += int'(in_ack); end
    chk("empty_noack", acks, 0);
    host_in_valid = 1'b1; host_in_data = 16'h07; tick();
    host_in_valid = 1'b0;
    chk("late_push_t", in_ack, 0);
    tick();
    chk("late_push_ack", in_ack, 1);
    chk("late_push_data", io_in, 16'h07);
    in_req = 1'b0; tick();

    // End of input
    host_in_valid = 1'b1; host_in_data = 16'h01; tick();
    host_in_valid = 1'b0; host_eof = 1'b1; tick();
    host_eof = 1'b0;
    chk("eof_pending", eof, 0);
    chk("eof_in_ready", host_in_ready, 0);
    host_in_valid = 1'b1; host_in_data = 16'h99; tick();
    host_in_valid = 1'b0;
    in_req = 1'b1; tick();
    chk("eof_rd_ack", in_ack, 1);
    chk("eof_rd_data", io_in, 16'h01);
    chk("eof_set", eof, 1);
    in_req = 1'b0; tick();
    in_req = 1'b1; acks = 0;
    repeat (10) begin tick(); acks += int'(in_ack); end
    chk("eof_noack", acks, 0);
    chk("eof_held", eof, 1);
    in_req = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("eof_cleared", eof, 0);

    // TX backpressure
    host_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      out_req = 1'b1; io_out = W'(i); tick();
      chk("tx_wr_ack", out_ack, 1);
      out_req = 1'b0; tick();
    end
    chk("tx_full_valid", host_out_valid, 1);
    out_req = 1'b1; io_out = 16'h10; acks = 0;
    repeat (5) begin tick(); acks += int'(out_ack); end
    chk("tx_full_noack", acks, 0);
    host_out_ready = 1'b1; got = 1'b0; seen.delete();
    for (int c = 0; c < 60; c++) begin
      if (out_ack) begin got = 1'b1; out_req = 1'b0; end
      if (host_out_valid) seen.push_back(host_out_data);
      tick();
    end
    out_req = 1'b0;
    chk("tx_late_ack", got, 1);
    chk("tx_drain_cnt", seen.size(), 17);
    for (int i = 0; i < seen.size() && i < 17; i++) chk("tx_drain_order", seen[i], i);

    // Reset during a read ack with RX and TX both holding data
    host_out_ready = 1'b0;
    out_req = 1'b1; io_out = 16'h55; tick();
    out_req = 1'b0; tick();
    host_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin host_in_data = W'(16'hA1 + i); tick(); end
    host_in_valid = 1'b0;
    in_req = 1'b1; tick();
    chk("rstack_pre_ack", in_ack, 1);
    chk("rstack_pre_data", io_in, 16'hA1);
    rst = 1'b1; in_req = 1'b0; tick();
    chk("rstack_in_ack", in_ack, 0);
    chk("rstack_io_in", io_in, 0);
    chk("rstack_out_valid", host_out_valid, 0);
    chk("rstack_in_ready", host_in_ready, 0);
    rst = 1'b0; in_req = 1'b1; acks = 0;
    repeat (5) begin tick(); acks += int'(in_ack); end
    chk("rstack_rx_empty", acks, 0);
    in_req = 1'b0; tick();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if (!in_req) in_req = (c % 700 < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      else if (in_ack && $urandom_range(0, 1) == 1) in_req = 1'b0;
      if (!out_req) begin
        out_req = ($urandom_range(0, 2) == 0);
        io_out  = W'($urandom);
      end else if (out_ack && $urandom_range(0, 1) == 1) out_req = 1'b0;
      host_in_valid  = $urandom_range(0, 1) == 1;
      host_in_data   = W'($urandom);
      host_eof       = ($urandom_range(0, 599) == 0);
      host_out_ready = (c % 500 < 350) ? ($urandom_range(0, 3) != 0) : 1'b0;
      tick();
    end
    rst = 1'b0; in_req = 1'b0; out_req = 1'b0; host_in_valid = 1'b0; host_eof = 1'b0;
    tick();
    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
